mdu_unit: RTL and testbench



---
 rtl/mdu_unit_if.sv | 23 ++
 rtl/mdu_unit.sv | 84 ++++++++
 tb/tb_mdu_unit.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/mdu_unit_if.sv
// MDU control/data bundle between the E-stage controller (master) and the multiply/divide unit (slave).
interface mdu_unit_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we,
        input  busy, stall_req, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we,
        output busy, stall_req, hi, lo
    );
endinterface

// File: rtl/mdu_unit.sv
// Multi-cycle mult/multu/div/divu into HI/LO; result lands MULT_CYCLES/DIV_CYCLES edges after accept.
// No backpressure input: start while busy and mthi/mtlo while busy are dropped; stall_req = start | busy.
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic      clk,
    input  logic      rst_n,
    mdu_unit_if.slave mdu
);
    localparam int CMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);

    logic [CW-1:0] cnt;
    logic [31:0]   hi_q;
    logic [31:0]   lo_q;
    logic [63:0]   res_q;
    logic          div0_q;

    logic [63:0]   prod_s;
    logic [63:0]   prod_u;
    logic [31:0]   dvs_s;
    logic [31:0]   dvs_u;
    logic          div_ovf;
    logic          is_div;
    logic          div0_c;
    logic [63:0]   res_c;
    logic          busy_w;

    assign busy_w = (cnt != '0);

    assign prod_s = $signed({{32{mdu.a[31]}}, mdu.a}) * $signed({{32{mdu.b[31]}}, mdu.b});
    assign prod_u = {32'd0, mdu.a} * {32'd0, mdu.b};

    // Dividing 0x80000000 by 1 instead of -1 gives exactly the architected
    // overflow result (LO=0x80000000, HI=0) without an undefined host divide.
    assign div_ovf = (mdu.a == 32'h8000_0000) && (mdu.b == 32'hFFFF_FFFF);
    assign dvs_s   = ((mdu.b == 32'd0) || div_ovf) ? 32'd1 : mdu.b;
    assign dvs_u   = (mdu.b == 32'd0) ? 32'd1 : mdu.b;

    assign is_div = (mdu.op == 3'd2) || (mdu.op == 3'd3);
    assign div0_c = is_div && (mdu.b == 32'd0);

    always_comb begin
        res_c = prod_s;
        case (mdu.op)
            3'd1:    res_c = prod_u;
            3'd2:    res_c = {32'($signed(mdu.a) % $signed(dvs_s)),
                              32'($signed(mdu.a) / $signed(dvs_s))};
            3'd3:    res_c = {mdu.a % dvs_u, mdu.a / dvs_u};
            default: res_c = prod_s;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            res_q  <= '0;
            div0_q <= 1'b0;
        end else if (busy_w) begin
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1) && !div0_q) begin
                hi_q <= res_q[63:32];
                lo_q <= res_q[31:0];
            end
        end else if (mdu.start) begin
            cnt    <= is_div ? DIV_N : MULT_N;
            res_q  <= res_c;
            div0_q <= div0_c;
        end else begin
            if (mdu.hi_we) hi_q <= mdu.a;
            if (mdu.lo_we) lo_q <= mdu.a;
        end
    end

    assign mdu.busy      = busy_w;
    assign mdu.stall_req = mdu.start | busy_w;
    assign mdu.hi        = hi_q;
    assign mdu.lo        = lo_q;
endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit: latency, arithmetic results, ignore rules and async reset.
module tb_mdu_unit;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mdu_unit_if mif();

    mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mdu   (mif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        mif.op    = op;
        mif.a     = a;
        mif.b     = b;
        mif.start = 1'b1;
        cyc();
        mif.start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (mif.busy === 1'b1 && n < 50) begin
            n++;
            cyc();
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        mif.start = 1'b0;
        mif.op    = 3'd0;
        mif.a     = 32'd0;
        mif.b     = 32'd0;
        mif.hi_we = 1'b0;
        mif.lo_we = 1'b0;
        #3;
        checks++; if (mif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", mif.busy); end
        checks++; if (mif.stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", mif.stall_req); end
        checks++; if (mif.hi !== 32'd0) begin errors++; $display("FAIL reset_hi got %h want 0", mif.hi); end
        checks++; if (mif.lo !== 32'd0) begin errors++; $display("FAIL reset_lo got %h want 0", mif.lo); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_mult();
        int n;
        launch(3'd0, 32'hFFFF_FFFE, 32'd3);
        checks++; if (mif.busy !== 1'b1) begin errors++; $display("FAIL mult_busy got %b want 1", mif.busy); end
        checks++; if (mif.stall_req !== 1'b1) begin errors++; $display("FAIL mult_stall got %b want 1", mif.stall_req); end
        checks++; if (mif.hi !== 32'd0) begin errors++; $display("FAIL mult_hi_hold got %h want 0", mif.hi); end
        wait_done(n);
        checks++; if (n != 5) begin errors++; $display("FAIL mult_cycles got %0d want 5", n); end
        checks++; if (mif.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h want ffffffff", mif.hi); end
        checks++; if (mif.lo !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_lo got %h want fffffffa", mif.lo); end
    endtask

    task automatic test_multu();
        int n;
        launch(3'd1, 32'hFFFF_FFFF, 32'd2);
        wait_done(n);
        checks++; if (n != 5) begin errors++; $display("FAIL multu_cycles got %0d want 5", n); end
        checks++; if (mif.hi !== 32'h0000_0001) begin errors++; $display("FAIL multu_hi got %h want 00000001", mif.hi); end
        checks++; if (mif.lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_lo got %h want fffffffe", mif.lo); end
    endtask

    task automatic test_div();
        int n;
        launch(3'd2, 32'hFFFF_FFF9, 32'd2);
        wait_done(n);
        checks++; if (n != 10) begin errors++; $display("FAIL div_cycles got %0d want 10", n); end
        checks++; if (mif.lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo got %h want fffffffd", mif.lo); end
        checks++; if (mif.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi got %h want ffffffff", mif.hi); end
        launch(3'd3, 32'd7, 32'd0);
        wait_done(n);
        checks++; if (n != 10) begin errors++; $display("FAIL divz_cycles got %0d want 10", n); end
        checks++; if (mif.lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL divz_lo got %h want fffffffd", mif.lo); end
        checks++; if (mif.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divz_hi got %h want ffffffff", mif.hi); end
    endtask

    task automatic test_div_overflow();
        int n;
        launch(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(n);
        checks++; if (n != 10) begin errors++; $display("FAIL ovf_cycles got %0d want 10", n); end
        checks++; if (mif.lo !== 32'h8000_0000) begin errors++; $display("FAIL ovf_lo got %h want 80000000", mif.lo); end
        checks++; if (mif.hi !== 32'd0) begin errors++; $display("FAIL ovf_hi got %h want 0", mif.hi); end
    endtask

    task automatic test_busy_ignore();
        int n;
        launch(3'd3, 32'd100, 32'd7);
        mif.start = 1'b1;
        mif.op    = 3'd0;
        mif.a     = 32'h0000_1234;
        mif.b     = 32'd5;
        mif.hi_we = 1'b1;
        mif.lo_we = 1'b1;
        cyc();
        mif.start = 1'b0;
        mif.hi_we = 1'b0;
        mif.lo_we = 1'b0;
        checks++; if (mif.busy !== 1'b1) begin errors++; $display("FAIL ign_busy got %b want 1", mif.busy); end
        checks++; if (mif.hi !== 32'd0) begin errors++; $display("FAIL ign_hi_hold got %h want 0", mif.hi); end
        checks++; if (mif.lo !== 32'h8000_0000) begin errors++; $display("FAIL ign_lo_hold got %h want 80000000", mif.lo); end
        wait_done(n);
        checks++; if (n != 9) begin errors++; $display("FAIL ign_remaining got %0d want 9", n); end
        checks++; if (mif.hi !== 32'd2) begin errors++; $display("FAIL ign_hi got %h want 00000002", mif.hi); end
        checks++; if (mif.lo !== 32'd14) begin errors++; $display("FAIL ign_lo got %h want 0000000e", mif.lo); end
    endtask

    task automatic test_mthi_mtlo();
        mif.hi_we = 1'b1;
        mif.a     = 32'hAAAA_0000;
        cyc();
        mif.hi_we = 1'b0;
        checks++; if (mif.hi !== 32'hAAAA_0000) begin errors++; $display("FAIL mthi_hi got %h want aaaa0000", mif.hi); end
        checks++; if (mif.lo !== 32'd14) begin errors++; $display("FAIL mthi_lo got %h want 0000000e", mif.lo); end
        mif.lo_we = 1'b1;
        mif.a     = 32'h0000_5555;
        cyc();
        mif.lo_we = 1'b0;
        checks++; if (mif.lo !== 32'h0000_5555) begin errors++; $display("FAIL mtlo_lo got %h want 00005555", mif.lo); end
        checks++; if (mif.hi !== 32'hAAAA_0000) begin errors++; $display("FAIL mtlo_hi got %h want aaaa0000", mif.hi); end
        mif.hi_we = 1'b1;
        mif.lo_we = 1'b1;
        mif.a     = 32'h1357_2468;
        cyc();
        mif.hi_we = 1'b0;
        mif.lo_we = 1'b0;
        checks++; if (mif.hi !== 32'h1357_2468) begin errors++; $display("FAIL both_hi got %h want 13572468", mif.hi); end
        checks++; if (mif.lo !== 32'h1357_2468) begin errors++; $display("FAIL both_lo got %h want 13572468", mif.lo); end
    endtask

    task automatic test_start_wins();
        int n;
        mif.hi_we = 1'b1;
        launch(3'd0, 32'h0001_0000, 32'h0001_0000);
        mif.hi_we = 1'b0;
        checks++; if (mif.hi !== 32'h1357_2468) begin errors++; $display("FAIL sw_hi_hold got %h want 13572468", mif.hi); end
        wait_done(n);
        checks++; if (n != 5) begin errors++; $display("FAIL sw_cycles got %0d want 5", n); end
        checks++; if (mif.hi !== 32'd1) begin errors++; $display("FAIL sw_hi got %h want 00000001", mif.hi); end
        checks++; if (mif.lo !== 32'd0) begin errors++; $display("FAIL sw_lo got %h want 0", mif.lo); end
    endtask

    task automatic test_reset_mid();
        mif.start = 1'b1;
        #1;
        checks++; if (mif.stall_req !== 1'b1) begin errors++; $display("FAIL comb_stall_hi got %b want 1", mif.stall_req); end
        checks++; if (mif.busy !== 1'b0) begin errors++; $display("FAIL comb_busy got %b want 0", mif.busy); end
        mif.start = 1'b0;
        #1;
        checks++; if (mif.stall_req !== 1'b0) begin errors++; $display("FAIL comb_stall_lo got %b want 0", mif.stall_req); end
        launch(3'd0, 32'd3, 32'd4);
        cyc();
        cyc();
        rst_n = 1'b0;
        #1;
        checks++; if (mif.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", mif.busy); end
        checks++; if (mif.hi !== 32'd0) begin errors++; $display("FAIL rst_mid_hi got %h want 0", mif.hi); end
        checks++; if (mif.lo !== 32'd0) begin errors++; $display("FAIL rst_mid_lo got %h want 0", mif.lo); end
        #2;
        rst_n = 1'b1;
        repeat (8) cyc();
        checks++; if (mif.busy !== 1'b0) begin errors++; $display("FAIL rst_after_busy got %b want 0", mif.busy); end
        checks++; if (mif.hi !== 32'd0) begin errors++; $display("FAIL rst_after_hi got %h want 0", mif.hi); end
        checks++; if (mif.lo !== 32'd0) begin errors++; $display("FAIL rst_after_lo got %h want 0", mif.lo); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_div_overflow();
        test_busy_ignore();
        test_mthi_mtlo();
        test_start_wins();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
